// File: rtl/pipeline_sequencer.sv
// Fetch/decode/execute cycle sequencer: reset hold, fetch wait-states, N-cycle execute, PC redirect.
// Define SEQ_PERF_COUNT_EN to build the retired/stall performance counters; otherwise they read 0.
module pipeline_sequencer #(
    parameter int RESET_CYCLES    = 2,
    parameter int MAX_EXEC_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int COUNT_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_ready,
    input  logic [CNT_W-1:0]   dec_exec_cycles,
    input  logic               dec_mem_access,
    input  logic               dec_branch,
    output logic [2:0]         state,
    output logic               control_reset,
    output logic               fetch_latch_en,
    output logic               decode_latch_en,
    output logic               exec_active,
    output logic [CNT_W-1:0]   exec_cycle,
    output logic               exec_last,
    output logic [1:0]         address_reg_sel,
    output logic               update_address,
    output logic               reg_pc_write_en,
    output logic               stall,
    output logic [COUNT_W-1:0] retired_count,
    output logic [COUNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        RST_HOLD = 3'b000,
        RST_PC   = 3'b001,
        FETCH    = 3'b010,
        DECODE   = 3'b011,
        EXECUTE  = 3'b100
    } state_t;

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t             cur_state;
    state_t             next_state;
    logic [RST_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]   exec_cnt;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   len_clamped;
    logic               mem_q;
    logic               branch_q;
    logic               last;
    logic               complete;

    assign state      = cur_state;
    assign last       = (cur_state == EXECUTE) && (exec_cnt == len - 1'b1);
    assign exec_last  = last;
    assign exec_cycle = exec_active ? exec_cnt : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur_state <= RST_HOLD;
        else
            cur_state <= next_state;
    end

    always_comb begin
        next_state      = cur_state;
        control_reset   = 1'b0;
        fetch_latch_en  = 1'b0;
        decode_latch_en = 1'b0;
        exec_active     = 1'b0;
        address_reg_sel = 2'b01;
        update_address  = 1'b0;
        reg_pc_write_en = 1'b0;
        stall           = 1'b0;
        complete        = 1'b0;
        case (cur_state)
            RST_HOLD: begin
                control_reset = 1'b1;
                if (rst_cnt == RST_W'(RESET_CYCLES - 1))
                    next_state = RST_PC;
            end
            RST_PC: begin
                update_address = 1'b1;
                next_state     = FETCH;
            end
            FETCH: begin
                fetch_latch_en = mem_ready;
                stall          = !mem_ready;
                if (mem_ready)
                    next_state = DECODE;
            end
            DECODE: begin
                decode_latch_en = 1'b1;
                next_state      = EXECUTE;
            end
            EXECUTE: begin
                exec_active = 1'b1;
                if (last) begin
                    // A load/store holds the final cycle until memory accepts it
                    if (mem_q && !mem_ready) begin
                        stall = 1'b1;
                    end else begin
                        complete        = 1'b1;
                        update_address  = 1'b1;
                        reg_pc_write_en = 1'b1;
                        address_reg_sel = branch_q ? 2'b00 : 2'b10;
                        next_state      = FETCH;
                    end
                end
            end
            default: begin
                control_reset = 1'b1;
                next_state    = RST_HOLD;
            end
        endcase
    end

    always_comb begin
        len_clamped = dec_exec_cycles;
        if (dec_exec_cycles == '0)
            len_clamped = CNT_W'(1);
        else if (dec_exec_cycles > CNT_W'(MAX_EXEC_CYCLES))
            len_clamped = CNT_W'(MAX_EXEC_CYCLES);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt  <= '0;
            exec_cnt <= '0;
            len      <= '0;
            mem_q    <= 1'b0;
            branch_q <= 1'b0;
        end else begin
            rst_cnt <= (cur_state == RST_HOLD) ? rst_cnt + 1'b1 : '0;
            if (cur_state == DECODE) begin
                len      <= len_clamped;
                mem_q    <= dec_mem_access;
                branch_q <= dec_branch;
                exec_cnt <= '0;
            end else if (cur_state == EXECUTE && !last) begin
                exec_cnt <= exec_cnt + 1'b1;
            end
        end
    end

`ifdef SEQ_PERF_COUNT_EN
    logic [COUNT_W-1:0] retired_q;
    logic [COUNT_W-1:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (complete)
                retired_q <= retired_q + COUNT_W'(1);
            if (stall)
                stall_q <= stall_q + COUNT_W'(1);
        end
    end

    assign retired_count = retired_q;
    assign stall_count   = stall_q;
`else
    logic unused_complete;
    assign unused_complete = complete;
    assign retired_count   = '0;
    assign stall_count     = '0;
`endif

endmodule
